// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m
//   Two-master, one-slave Wishbone classic arbiter with a bus-hang watchdog.
//   The mips32r1 instruction master (m0) and data master (m1) share a single
//   slave-side bus. The arbiter grants whole bus cycles: a master keeps the
//   grant for as long as it holds cyc. Simultaneous requests from idle are
//   resolved round-robin. A transfer whose strobe stalls for TIMEOUT cycles is
//   terminated with a synthesized err.
//
// Ports
//   wb_clk_i, wb_rst_n_i        bus clock, asynchronous active-low reset
//   m0_*_i / m1_*_i             master request side (adr, dat, sel, we, cyc, stb)
//   m0_*_o / m1_*_o             master response side (dat, ack, err)
//   s_*_o                       muxed request toward the slave
//   s_dat_i, s_ack_i, s_err_i   slave response
//   grant_o                     one-hot registered grant {m1,m0}, 00 when idle
//
// Parameters
//   AW, DW     address / data width (sel width is DW/8)
//   TO_W       watchdog counter width
//   TIMEOUT    stalled-strobe cycles before a synthesized err, 0 disables.
//              Must be below 2**TO_W.
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_n_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  localparam logic [TO_W-1:0] LP_TIMEOUT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LP_MAX     = {TO_W{1'b1}};

  state_t          r_state;
  state_t          w_nextState;
  // r_last = 1 means m1 was granted most recently, so m0 wins the next tie.
  logic            r_last;
  logic [TO_W-1:0] r_wdCnt;
  logic [TO_W-1:0] w_wdCntNext;
  logic            w_act0;
  logic            w_act1;
  logic            w_active;
  logic            w_stbMux;
  logic            w_wdErr;

  // A master is only connected through while it is granted and still holds
  // cyc; the release cycle therefore presents an idle bus to the slave and a
  // late slave ack in that cycle reaches nobody.
  assign w_act0   = (r_state == GNT0) && m0_cyc_i;
  assign w_act1   = (r_state == GNT1) && m1_cyc_i;
  assign w_active = w_act0 || w_act1;

  // Read data is broadcast unqualified; ack/err tell each master when it is valid.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign grant_o = {r_state == GNT1, r_state == GNT0};

  // Next-state selection and the request-side multiplexer. From IDLE a tie
  // goes to the master that was not granted last. On release the grant hands
  // straight over to a waiting master without passing through IDLE.
  always_comb begin
    w_nextState = r_state;
    s_adr_o     = '0;
    s_dat_o     = '0;
    s_sel_o     = '0;
    s_we_o      = 1'b0;
    s_cyc_o     = 1'b0;
    w_stbMux    = 1'b0;
    case (r_state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          w_nextState = r_last ? GNT0 : GNT1;
        end else if (m0_cyc_i) begin
          w_nextState = GNT0;
        end else if (m1_cyc_i) begin
          w_nextState = GNT1;
        end
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          w_nextState = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          w_nextState = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
    if (w_act0) begin
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_sel_o  = m0_sel_i;
      s_we_o   = m0_we_i;
      s_cyc_o  = 1'b1;
      w_stbMux = m0_stb_i;
    end else if (w_act1) begin
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_sel_o  = m1_sel_i;
      s_we_o   = m1_we_i;
      s_cyc_o  = 1'b1;
      w_stbMux = m1_stb_i;
    end
  end

  // The watchdog fires when the stalled-strobe count reaches TIMEOUT. In that
  // cycle the strobe is withdrawn from the slave so the aborted transfer cannot
  // complete behind the master's back, and err is reported instead.
  assign w_wdErr = (TIMEOUT != 0) && w_active && w_stbMux && (r_wdCnt == LP_TIMEOUT);
  assign s_stb_o = w_stbMux && !w_wdErr;

  // Slave err takes priority over a simultaneous ack.
  assign m0_ack_o = w_act0 && s_ack_i && !s_err_i && !w_wdErr;
  assign m0_err_o = w_act0 && (s_err_i || w_wdErr);
  assign m1_ack_o = w_act1 && s_ack_i && !s_err_i && !w_wdErr;
  assign m1_err_o = w_act1 && (s_err_i || w_wdErr);

  // Watchdog count: cleared whenever no master is connected (idle, release or
  // handover cycles) and on any termination; saturates instead of wrapping.
  always_comb begin
    w_wdCntNext = r_wdCnt;
    if (!w_active || w_wdErr || s_ack_i || s_err_i) begin
      w_wdCntNext = '0;
    end else if (s_stb_o && (r_wdCnt != LP_MAX)) begin
      w_wdCntNext = r_wdCnt + TO_W'(1);
    end
  end

  // State, round-robin history and watchdog registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wdCnt <= '0;
    end else begin
      r_state <= w_nextState;
      r_wdCnt <= w_wdCntNext;
      if (w_nextState == GNT0 && r_state != GNT0) begin
        r_last <= 1'b0;
      end else if (w_nextState == GNT1 && r_state != GNT1) begin
        r_last <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Testbench for wb_arbiter_2m. A table of per-cycle vectors covers single
// transfers, contention and round-robin, handover, write muxing, ack/err
// collision and late acks after release. Hand-written sequences cover the
// watchdog (TIMEOUT=4 and a second instance with TIMEOUT=0) and a reset
// asserted between clock edges in the middle of a transfer.
module tb_wb_arbiter_2m;

  typedef struct packed {
    logic        rst;
    logic        c0;
    logic        s0;
    logic        c1;
    logic        s1;
    logic        we1;
    logic [31:0] adr1;
    logic [31:0] dat1;
    logic [3:0]  sel1;
    logic        ack;
    logic        err;
    logic [1:0]  eGnt;
    logic [1:0]  eSrc;
    logic        eAck0;
    logic        eErr0;
    logic        eAck1;
    logic        eErr1;
  } vec_t;

  localparam logic [31:0] M0_ADR = 32'h0000_0000;
  localparam logic [31:0] M0_DAT = 32'h1111_1111;
  localparam logic [3:0]  M0_SEL = 4'hF;
  localparam logic [31:0] S_DAT  = 32'hCAFE_F00D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic [31:0] m0Adr, m0Dat, m1Adr, m1Dat, sDatI;
  logic [3:0]  m0Sel, m1Sel;
  logic        m0We, m0Cyc, m0Stb, m1We, m1Cyc, m1Stb, sAck, sErr;

  logic [31:0] m0DatO, m1DatO, sAdrO, sDatO;
  logic [3:0]  sSelO;
  logic        m0AckO, m0ErrO, m1AckO, m1ErrO, sWeO, sCycO, sStbO;
  logic [1:0]  grantO;

  logic [31:0] zM0DatO, zM1DatO, zSAdrO, zSDatO;
  logic [3:0]  zSSelO;
  logic        zM0AckO, zM0ErrO, zM1AckO, zM1ErrO, zSWeO, zSCycO, zSStbO;
  logic [1:0]  zGrantO;

  int   assertCount = 0;
  int   failCount   = 0;
  int   zErrSeen;
  logic expErr;
  vec_t vecs[$];

  wb_arbiter_2m #(.AW(32), .DW(32), .TO_W(8), .TIMEOUT(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rstN),
    .m0_adr_i(m0Adr), .m0_dat_i(m0Dat), .m0_sel_i(m0Sel), .m0_we_i(m0We),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb),
    .m0_dat_o(m0DatO), .m0_ack_o(m0AckO), .m0_err_o(m0ErrO),
    .m1_adr_i(m1Adr), .m1_dat_i(m1Dat), .m1_sel_i(m1Sel), .m1_we_i(m1We),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb),
    .m1_dat_o(m1DatO), .m1_ack_o(m1AckO), .m1_err_o(m1ErrO),
    .s_adr_o(sAdrO), .s_dat_o(sDatO), .s_sel_o(sSelO), .s_we_o(sWeO),
    .s_cyc_o(sCycO), .s_stb_o(sStbO),
    .s_dat_i(sDatI), .s_ack_i(sAck), .s_err_i(sErr), .grant_o(grantO)
  );

  wb_arbiter_2m #(.AW(32), .DW(32), .TO_W(8), .TIMEOUT(0)) dutNoWd (
    .wb_clk_i(clk), .wb_rst_n_i(rstN),
    .m0_adr_i(m0Adr), .m0_dat_i(m0Dat), .m0_sel_i(m0Sel), .m0_we_i(m0We),
    .m0_cyc_i(m0Cyc), .m0_stb_i(m0Stb),
    .m0_dat_o(zM0DatO), .m0_ack_o(zM0AckO), .m0_err_o(zM0ErrO),
    .m1_adr_i(m1Adr), .m1_dat_i(m1Dat), .m1_sel_i(m1Sel), .m1_we_i(m1We),
    .m1_cyc_i(m1Cyc), .m1_stb_i(m1Stb),
    .m1_dat_o(zM1DatO), .m1_ack_o(zM1AckO), .m1_err_o(zM1ErrO),
    .s_adr_o(zSAdrO), .s_dat_o(zSDatO), .s_sel_o(zSSelO), .s_we_o(zSWeO),
    .s_cyc_o(zSCycO), .s_stb_o(zSStbO),
    .s_dat_i(sDatI), .s_ack_i(sAck), .s_err_i(sErr), .grant_o(zGrantO)
  );

  // Builds one vector; wr selects the m1 write pattern, otherwise m1 issues a read.
  function automatic vec_t mk(input int rst, input int wr, input int c0, input int s0,
                              input int c1, input int s1, input int ack, input int err,
                              input int eGnt, input int eSrc, input int eA0, input int eE0,
                              input int eA1, input int eE1);
    vec_t v;
    v.rst   = rst[0];
    v.c0    = c0[0];
    v.s0    = s0[0];
    v.c1    = c1[0];
    v.s1    = s1[0];
    v.ack   = ack[0];
    v.err   = err[0];
    v.eGnt  = eGnt[1:0];
    v.eSrc  = eSrc[1:0];
    v.eAck0 = eA0[0];
    v.eErr0 = eE0[0];
    v.eAck1 = eA1[0];
    v.eErr1 = eE1[0];
    if (wr != 0) begin
      v.we1  = 1'b1;
      v.adr1 = 32'h1000_0004;
      v.dat1 = 32'hDEAD_BEEF;
      v.sel1 = 4'b0011;
    end else begin
      v.we1  = 1'b0;
      v.adr1 = 32'h0000_0020;
      v.dat1 = 32'h2222_2222;
      v.sel1 = 4'hF;
    end
    return v;
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rstN  = ~v.rst;
    m0Cyc = v.c0;
    m0Stb = v.s0;
    m1Cyc = v.c1;
    m1Stb = v.s1;
    m1We  = v.we1;
    m1Adr = v.adr1;
    m1Dat = v.dat1;
    m1Sel = v.sel1;
    sAck  = v.ack;
    sErr  = v.err;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    logic [31:0] eAdr, eDat;
    logic [3:0]  eSel;
    logic        eWe, eCyc, eStb;
    eAdr = '0; eDat = '0; eSel = '0; eWe = 1'b0; eCyc = 1'b0; eStb = 1'b0;
    if (v.eSrc == 2'd1) begin
      eAdr = M0_ADR; eDat = M0_DAT; eSel = M0_SEL; eWe = 1'b0; eCyc = 1'b1; eStb = v.s0;
    end else if (v.eSrc == 2'd2) begin
      eAdr = v.adr1; eDat = v.dat1; eSel = v.sel1; eWe = v.we1; eCyc = 1'b1; eStb = v.s1;
    end
    checkVal($sformatf("v%0d grant", idx), 32'(grantO), 32'(v.eGnt));
    checkVal($sformatf("v%0d s_cyc", idx), 32'(sCycO), 32'(eCyc));
    checkVal($sformatf("v%0d s_stb", idx), 32'(sStbO), 32'(eStb));
    checkVal($sformatf("v%0d s_adr", idx), sAdrO, eAdr);
    checkVal($sformatf("v%0d s_dat", idx), sDatO, eDat);
    checkVal($sformatf("v%0d s_sel", idx), 32'(sSelO), 32'(eSel));
    checkVal($sformatf("v%0d s_we", idx), 32'(sWeO), 32'(eWe));
    checkVal($sformatf("v%0d m0_ack", idx), 32'(m0AckO), 32'(v.eAck0));
    checkVal($sformatf("v%0d m0_err", idx), 32'(m0ErrO), 32'(v.eErr0));
    checkVal($sformatf("v%0d m1_ack", idx), 32'(m1AckO), 32'(v.eAck1));
    checkVal($sformatf("v%0d m1_err", idx), 32'(m1ErrO), 32'(v.eErr1));
    checkVal($sformatf("v%0d m0_dat_o", idx), m0DatO, S_DAT);
    checkVal($sformatf("v%0d m1_dat_o", idx), m1DatO, S_DAT);
  endtask

  // Absolute time limit so a broken design can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL global time limit reached: failures so far %0d, expected finish", failCount);
    $fatal(1, "[TB] time limit");
  end

  initial begin
    rstN = 1'b0;
    m0Adr = M0_ADR; m0Dat = M0_DAT; m0Sel = M0_SEL; m0We = 1'b0;
    m0Cyc = 1'b0; m0Stb = 1'b0;
    m1Adr = '0; m1Dat = '0; m1Sel = '0; m1We = 1'b0; m1Cyc = 1'b0; m1Stb = 1'b0;
    sDatI = S_DAT; sAck = 1'b0; sErr = 1'b0;

    // rst wr c0 s0 c1 s1 ack err | gnt src a0 e0 a1 e1
    // Reset state, then m0 single read acked on its third strobe cycle.
    vecs.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 0,0, 1,1, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 0,0, 1,1, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 1,0, 1,1, 1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 1,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    // m1 write with m0 waiting, handover to m0, then ack+err collision.
    vecs.push_back(mk(0,1, 0,0,1,1, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,1, 1,1,1,1, 0,0, 2,2, 0,0,0,0));
    vecs.push_back(mk(0,1, 1,1,1,1, 1,0, 2,2, 0,0,1,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 0,0, 2,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 0,0, 1,1, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 1,1, 1,1, 0,1,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 1,0, 0,0,0,0));
    // Late ack after m1 releases cyc reaches neither master.
    vecs.push_back(mk(0,0, 0,0,1,1, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,1,1, 0,0, 2,2, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 1,0, 2,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 1,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    // Fresh reset, contention: m0 first, 3 transfers each, direct handover.
    vecs.push_back(mk(1,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1,1, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1,1, 1,0, 1,1, 1,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1,1, 1,0, 1,1, 1,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1,1, 1,0, 1,1, 1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,1,1, 0,0, 1,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,1,1, 1,0, 2,2, 0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,1,1, 1,0, 2,2, 0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,1,1, 1,0, 2,2, 0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 2,0, 0,0,0,0));
    // Repeat contention: m1 was last, so m0 wins again.
    vecs.push_back(mk(0,0, 1,1,1,1, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1,1, 1,0, 1,1, 1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,1,1, 0,0, 1,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,1,1, 1,0, 2,2, 0,0,1,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 2,0, 0,0,0,0));
    // m0 alone, then a tie with m0 last: m1 wins.
    vecs.push_back(mk(0,0, 1,1,0,0, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 1,0, 1,1, 1,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 1,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1,1, 0,0, 0,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1,1, 0,0, 2,2, 0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,0,0, 0,0, 2,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 1,0, 0,0,0,0));
    vecs.push_back(mk(0,0, 0,0,0,0, 0,0, 0,0, 0,0,0,0));

    repeat (2) @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end

    // Watchdog: slave never responds. err after 4 stalled strobe cycles,
    // strobe withdrawn that cycle, then the count starts over.
    @(negedge clk);
    m1Cyc = 1'b1; m1Stb = 1'b1; m1We = 1'b0; m1Adr = 32'h0000_0030;
    sAck = 1'b0; sErr = 1'b0;
    #1;
    checkVal("wd grant before", 32'(grantO), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      expErr = (i == 4) || (i == 9);
      checkVal($sformatf("wd%0d m1_err", i), 32'(m1ErrO), 32'(expErr));
      checkVal($sformatf("wd%0d m1_ack", i), 32'(m1AckO), 32'd0);
      checkVal($sformatf("wd%0d s_stb", i), 32'(sStbO), 32'(!expErr));
      checkVal($sformatf("wd%0d s_cyc", i), 32'(sCycO), 32'd1);
      checkVal($sformatf("wd%0d nowd m1_err", i), 32'(zM1ErrO), 32'd0);
    end
    zErrSeen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1;
      if (zM1ErrO || zM0ErrO) zErrSeen++;
    end
    checkVal("nowd err count", 32'(zErrSeen), 32'd0);
    checkVal("nowd s_stb held", 32'(zSStbO), 32'd1);
    checkVal("nowd grant held", 32'(zGrantO), 32'd2);
    @(negedge clk);
    m1Cyc = 1'b0; m1Stb = 1'b0;
    @(negedge clk);
    #1;
    checkVal("wd release grant", 32'(grantO), 32'd0);

    // Reset dropped between clock edges in the middle of an m1 transfer.
    @(negedge clk);
    m1Cyc = 1'b1; m1Stb = 1'b1;
    @(negedge clk);
    #1;
    checkVal("rst pre grant", 32'(grantO), 32'd2);
    checkVal("rst pre s_cyc", 32'(sCycO), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkVal("rst mid s_cyc", 32'(sCycO), 32'd0);
    checkVal("rst mid s_stb", 32'(sStbO), 32'd0);
    checkVal("rst mid grant", 32'(grantO), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    checkVal("rst rel grant", 32'(grantO), 32'd0);
    @(negedge clk);
    #1;
    checkVal("rst regrant grant", 32'(grantO), 32'd2);
    checkVal("rst regrant s_cyc", 32'(sCycO), 32'd1);
    m1Cyc = 1'b0; m1Stb = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
Name: wb_arbiter_2m

Overview:
- Two-master, one-slave Wishbone classic arbiter with a bus-hang watchdog.
- Shares one slave-side bus (interconnect port toward rom0/uart0) between the mips32r1 instruction master (m0) and data master (m1).
- Grants whole bus cycles (held while the granted master keeps cyc high) and uses round-robin on contention.
- Terminates hung transfers with a synthesized err.

Parameters:
AW, 32, address width
DW, 32, data width (sel width = DW/8)
TO_W, 8, watchdog counter width
TIMEOUT, 255, stalled-strobe cycles before synthesized err; 0 disables watchdog

Ports:
wb_clk_i  in  1  bus clock
wb_rst_n_i  in  1  reset: asynchronous, active-low
m0_adr_i/m1_adr_i  in  AW  master address
m0_dat_i/m1_dat_i  in  DW  master write data
m0_sel_i/m1_sel_i  in  DW/8  byte selects
m0_we_i/m1_we_i  in  1  write enable
m0_cyc_i/m1_cyc_i  in  1  cycle request
m0_stb_i/m1_stb_i  in  1  strobe
m0_dat_o/m1_dat_o  out  DW  read data (= s_dat_i, unqualified)
m0_ack_o/m1_ack_o  out  1  ack to master
m0_err_o/m1_err_o  out  1  err to master
s_adr_o  out  AW  muxed address
s_dat_o  out  DW  muxed write data
s_sel_o  out  DW/8  muxed selects
s_we_o  out  1  muxed write enable
s_cyc_o  out  1  muxed cycle
s_stb_o  out  1  muxed strobe (gated, see watchdog)
s_dat_i  in  DW  slave read data
s_ack_i  in  1  slave ack
s_err_i  in  1  slave err
grant_o  out  2  one-hot current grant {m1,m0}; 00 when idle

Behaviour:
- Reset (wb_rst_n_i=0, async):
  - State=IDLE, last=m1 (so m0 wins the first tie), watchdog count=0.
  - All s_* outputs 0, all m*_ack_o/m*_err_o 0, grant_o=00.
  - Applies immediately, including mid-transfer.
- FSM states: IDLE, GNT0, GNT1. Grant is registered, so there is 1 cycle of arbitration latency from cyc rising to s_cyc_o rising.
- IDLE:
  - Only mX_cyc_i high -> GNTX.
  - Both high -> grant the master != last.
  - Neither -> stay IDLE.
  - All s_* outputs 0.
- GNTX, while mX_cyc_i=1:
  - s_adr/dat/sel/we/cyc/stb pass mX_* combinationally.
  - mX_ack_o = s_ack_i & ~s_err_i; mX_err_o = s_err_i | wd_err.
  - Other master's ack/err held 0, and it is not stalled beyond waiting.
- GNTX, cycle where mX_cyc_i=0:
  - s_cyc_o=0.
  - Next = GNTY if mY_cyc_i else IDLE (direct handover, no IDLE bubble).
- last is updated on every entry to GNT0/GNT1.
- A master holding cyc across multiple stb (burst/RMW) keeps the grant indefinitely; there is no preemption.
- Simultaneous s_ack_i and s_err_i: err wins and ack is suppressed.
- Watchdog:
  - Counter increments each GNTX cycle with s_stb_o & ~s_ack_i & ~s_err_i.
  - Cleared on ack, err, grant change, or IDLE.
  - When the count equals TIMEOUT: wd_err pulses 1 cycle to the granted master, s_stb_o is forced 0 that cycle, and the counter clears.
  - Counter saturates rather than wraps; TIMEOUT must be < 2^TO_W.
  - TIMEOUT=0 disables the watchdog (wd_err never asserts).
- Releasing cyc while stb is pending aborts the transfer. A late s_ack_i arriving after release is not routed to either master.
- grant_o is the registered FSM state decode.

Test Plan:
1. Reset released, m0 reads 0x000 with slave ack after 2 cycles -> s_cyc_o high 1 cycle after m0_cyc_i; m0_ack_o pulses once; m1_ack_o stays 0; grant_o=01 then 00.
2. m0 and m1 raise cyc in the same cycle, each holding it for 3 single transfers -> m0 granted first (grant_o=01). On m0 release, grant_o goes straight to 10 with no IDLE cycle. Repeat contention -> m0 next (alternation).
3. m1 writes 0xDEADBEEF, sel=4'b0011, to 0x1000_0004 -> s_adr_o/s_dat_o/s_sel_o/s_we_o match exactly on the strobe cycle; m0 is held off until m1_cyc_i drops.
4. Slave never acks with TIMEOUT=4 -> m1_err_o pulses exactly 4 stalled cycles after stb; s_stb_o is 0 that cycle; count restarts. With TIMEOUT=0 -> no err within 300 cycles.
5. Slave asserts ack and err together -> granted master sees err=1, ack=0.
6. wb_rst_n_i pulled low mid-transfer, between clock edges -> s_cyc_o, s_stb_o, and grant_o drop to 0 immediately. After release, a m1-only request is granted in 1 cycle.
